// File: rtl/jt5205_feeder_if.sv
// jt5205_feeder_if: bundle of the CPU-side and decoder-side signals of the
// jt5205 sample feeder.
//   wr, din, play, clr         : CPU byte writes and playback control
//   dout, adpcm_rst            : nibble and reset towards the jt5205 core
//   low, ovf, unf, count       : FIFO status back to the CPU
// master modport: the side that writes bytes and reads status (CPU / bench)
// slave modport : the feeder itself
interface jt5205_feeder_if #(
  parameter int AW = 4
);
  logic          wr;
  logic [7:0]    din;
  logic          play;
  logic          clr;
  logic [3:0]    dout;
  logic          adpcm_rst;
  logic          low;
  logic          ovf;
  logic          unf;
  logic [AW:0]   count;

  modport master (
    output wr, din, play, clr,
    input  dout, adpcm_rst, low, ovf, unf, count
  );

  modport slave (
    input  wr, din, play, clr,
    output dout, adpcm_rst, low, ovf, unf, count
  );
endinterface

// File: rtl/jt5205_feeder.sv
// jt5205_feeder: sample source for the jt5205 ADPCM decoder.
// The CPU pushes packed ADPCM bytes into a 2**AW byte FIFO; on every sample
// strobe (cen & vclk) during playback the next 4-bit nibble is presented on
// dout. The decoder reset is held while stopped, priming or starved.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   cen    clock enable shared with the jt5205 core
//   vclk   sample strobe, qualified by cen
//   bus    jt5205_feeder_if.slave (wr, din, play, clr, dout, adpcm_rst,
//          low, ovf, unf, count)
// Build option: JT5205_FEEDER_LOFIRST_EN plays din[3:0] before din[7:4];
// without it the high nibble is played first.
module jt5205_feeder #(
  parameter int AW      = 4,
  parameter int LOWMARK = 4,
  parameter int PRIME   = 2
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             vclk,
  jt5205_feeder_if.slave   bus
);

  localparam int unsigned DEPTH     = 2**AW;
  localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LOW_LVL   = (AW+1)'(LOWMARK);
  localparam logic [AW:0] PRIME_LVL = (AW+1)'(PRIME);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RUN
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          nib_sel;    // 0: first nibble of head byte is due next
  logic [3:0]    dout_r;
  logic          arst_r;
  logic          ovf_r;
  logic          unf_r;

  logic [7:0]    head;
  logic [3:0]    nib_first;
  logic [3:0]    nib_second;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;

  always_comb begin
    head = mem[rptr];
`ifdef JT5205_FEEDER_LOFIRST_EN
    nib_first  = head[3:0];
    nib_second = head[7:4];
`else
    nib_first  = head[7:4];
    nib_second = head[3:0];
`endif
    empty = (cnt == '0);
    full  = (cnt == FULL_LVL);
    // The head byte leaves the FIFO only once its second nibble is played,
    // so a same-cycle push into an empty FIFO can never satisfy a pop.
    pop   = !bus.clr && (state == RUN) && bus.play && cen && vclk &&
            nib_sel && !empty;
    // A full FIFO still accepts a byte when the head is popped this cycle.
    push  = !bus.clr && bus.wr && (!full || pop);
  end

  // FIFO storage: no reset needed, occupancy is tracked by cnt
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.din;
  end

  // FIFO pointers, occupancy and overflow flag run every clk, ignoring cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else if (bus.clr) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (bus.wr && full && !pop) ovf_r <= 1'b1;
    end
  end

  // Playback FSM; transitions only on cen cycles, outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      nib_sel <= 1'b0;
      dout_r  <= '0;
      arst_r  <= 1'b1;
      unf_r   <= 1'b0;
    end else if (bus.clr) begin
      state   <= bus.play ? WAIT : IDLE;
      nib_sel <= 1'b0;
      dout_r  <= '0;
      arst_r  <= 1'b1;
      unf_r   <= 1'b0;
    end else if (cen) begin
      case (state)
        IDLE: begin
          arst_r <= 1'b1;
          dout_r <= '0;
          if (bus.play) state <= WAIT;
        end
        WAIT: begin
          arst_r <= 1'b1;
          if (!bus.play) begin
            state  <= IDLE;
            dout_r <= '0;
          end else if (cnt >= PRIME_LVL) begin
            state  <= RUN;
            arst_r <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.play) begin
            // nibble pointer and FIFO are kept so playback resumes mid-byte
            state  <= IDLE;
            arst_r <= 1'b1;
            dout_r <= '0;
          end else if (vclk) begin
            if (!nib_sel) begin
              if (empty) begin
                state  <= WAIT;
                unf_r  <= 1'b1;
                arst_r <= 1'b1;
                dout_r <= '0;
              end else begin
                dout_r  <= nib_first;
                nib_sel <= 1'b1;
              end
            end else begin
              dout_r  <= nib_second;
              nib_sel <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          arst_r <= 1'b1;
          dout_r <= '0;
        end
      endcase
    end
  end

  assign bus.dout      = dout_r;
  assign bus.adpcm_rst = arst_r;
  assign bus.ovf       = ovf_r;
  assign bus.unf       = unf_r;
  assign bus.count     = cnt;
  assign bus.low       = (cnt <= LOW_LVL);

endmodule

// File: tb/tb_jt5205_feeder.sv
// tb_jt5205_feeder: directed, table-driven bench for jt5205_feeder
// (AW=4, LOWMARK=4, PRIME=2). Nibble order follows JT5205_FEEDER_LOFIRST_EN.
module tb_jt5205_feeder;

  localparam int AW      = 4;
  localparam int LOWMARK = 4;
  localparam int PRIME   = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic cen;
  logic vclk;

  jt5205_feeder_if #(.AW(AW)) bus ();

  jt5205_feeder #(
    .AW      (AW),
    .LOWMARK (LOWMARK),
    .PRIME   (PRIME)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .vclk  (vclk),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       cen;
    logic       vclk;
    logic       wr;
    logic [7:0] din;
    logic       play;
    logic       clr;
    logic [3:0] dout;
    logic       arst;
    int         cnt;
    logic       ovf;
    logic       unf;
  } vec_t;

  int nvec = 0;
  int nfail = 0;

  function automatic logic [3:0] n1(input logic [7:0] b);
`ifdef JT5205_FEEDER_LOFIRST_EN
    return b[3:0];
`else
    return b[7:4];
`endif
  endfunction

  function automatic logic [3:0] n2(input logic [7:0] b);
`ifdef JT5205_FEEDER_LOFIRST_EN
    return b[7:4];
`else
    return b[3:0];
`endif
  endfunction

  function automatic vec_t mk(input string n, input logic c, input logic v,
                              input logic w, input logic [7:0] d,
                              input logic p, input logic cl,
                              input logic [3:0] ed, input logic er,
                              input int ec, input logic eo, input logic eu);
    vec_t r;
    r.name = n; r.cen = c; r.vclk = v; r.wr = w; r.din = d; r.play = p;
    r.clr = cl; r.dout = ed; r.arst = er; r.cnt = ec; r.ovf = eo; r.unf = eu;
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] ed,
                       input logic er, input int ec, input logic eo,
                       input logic eu);
    logic el;
    el = (ec <= LOWMARK);
    nvec++;
    if (bus.dout !== ed || bus.adpcm_rst !== er || bus.count !== 5'(ec) ||
        bus.low !== el || bus.ovf !== eo || bus.unf !== eu) begin
      nfail++;
      $display("FAIL %s: got dout=%h rst=%b count=%0d low=%b ovf=%b unf=%b, want dout=%h rst=%b count=%0d low=%b ovf=%b unf=%b",
               name, bus.dout, bus.adpcm_rst, bus.count, bus.low, bus.ovf,
               bus.unf, ed, er, ec, el, eo, eu);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    cen      = v.cen;
    vclk     = v.vclk;
    bus.wr   = v.wr;
    bus.din  = v.din;
    bus.play = v.play;
    bus.clr  = v.clr;
    @(posedge clk);
    #1;
    check(v.name, v.dout, v.arst, v.cnt, v.ovf, v.unf);
  endtask

  vec_t tbl [14];

  initial begin
    // A5, 3C playback, cen gating, underrun, clr
    tbl[0]  = mk("wr_a5",        1, 0, 1, 8'hA5, 0, 0, 4'h0,     1, 1, 0, 0);
    tbl[1]  = mk("wr_3c",        1, 0, 1, 8'h3C, 0, 0, 4'h0,     1, 2, 0, 0);
    tbl[2]  = mk("idle_to_wait", 1, 0, 0, 8'h00, 1, 0, 4'h0,     1, 2, 0, 0);
    tbl[3]  = mk("wait_nocen",   0, 0, 0, 8'h00, 1, 0, 4'h0,     1, 2, 0, 0);
    tbl[4]  = mk("wait_to_run",  1, 0, 0, 8'h00, 1, 0, 4'h0,     0, 2, 0, 0);
    tbl[5]  = mk("nib_a_hi",     1, 1, 0, 8'h00, 1, 0, n1(8'hA5), 0, 2, 0, 0);
    tbl[6]  = mk("vclk_nocen",   0, 1, 0, 8'h00, 1, 0, n1(8'hA5), 0, 2, 0, 0);
    tbl[7]  = mk("nib_a_lo",     1, 1, 0, 8'h00, 1, 0, n2(8'hA5), 0, 1, 0, 0);
    tbl[8]  = mk("nib_c_hi",     1, 1, 0, 8'h00, 1, 0, n1(8'h3C), 0, 1, 0, 0);
    tbl[9]  = mk("nib_c_lo",     1, 1, 0, 8'h00, 1, 0, n2(8'h3C), 0, 0, 0, 0);
    tbl[10] = mk("underrun",     1, 1, 0, 8'h00, 1, 0, 4'h0,     1, 0, 0, 1);
    tbl[11] = mk("wait_unprimed",1, 0, 0, 8'h00, 1, 0, 4'h0,     1, 0, 0, 1);
    tbl[12] = mk("clr_flags",    1, 0, 0, 8'h00, 1, 1, 4'h0,     1, 0, 0, 0);
    tbl[13] = mk("clr_beats_wr", 1, 0, 1, 8'hFF, 0, 1, 4'h0,     1, 0, 0, 0);

    rst_n = 1'b0; cen = 1'b0; vclk = 1'b0;
    bus.wr = 1'b0; bus.din = '0; bus.play = 1'b0; bus.clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", 4'h0, 1, 0, 0, 0);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 14; i++) apply(tbl[i]);

    // fill to full and overflow with play=0, then flush
    for (int unsigned i = 0; i < 17; i++)
      apply(mk($sformatf("fill_%0d", i), 1, 0, 1, 8'(i), 0, 0, 4'h0, 1,
               (i + 1 > 16) ? 16 : int'(i + 1), (i == 16), 0));
    apply(mk("clr_full", 1, 0, 0, 8'h00, 0, 1, 4'h0, 1, 0, 0, 0));

    // single byte 71 left in RUN: 7, 1, then underrun
    apply(mk("s3_wr22",   1, 0, 1, 8'h22, 0, 0, 4'h0, 1, 1, 0, 0));
    apply(mk("s3_wr71",   1, 0, 1, 8'h71, 0, 0, 4'h0, 1, 2, 0, 0));
    apply(mk("s3_wait",   1, 0, 0, 8'h00, 1, 0, 4'h0, 1, 2, 0, 0));
    apply(mk("s3_run",    1, 0, 0, 8'h00, 1, 0, 4'h0, 0, 2, 0, 0));
    apply(mk("s3_n22a",   1, 1, 0, 8'h00, 1, 0, n1(8'h22), 0, 2, 0, 0));
    apply(mk("s3_n22b",   1, 1, 0, 8'h00, 1, 0, n2(8'h22), 0, 1, 0, 0));
    apply(mk("s3_n71a",   1, 1, 0, 8'h00, 1, 0, n1(8'h71), 0, 1, 0, 0));
    apply(mk("s3_n71b",   1, 1, 0, 8'h00, 1, 0, n2(8'h71), 0, 0, 0, 0));
    apply(mk("s3_unf",    1, 1, 0, 8'h00, 1, 0, 4'h0, 1, 0, 0, 1));
    apply(mk("s3_held",   1, 0, 0, 8'h00, 1, 0, 4'h0, 1, 0, 0, 1));

    // stop after the first nibble of 71, resume mid-byte
    apply(mk("s4_clr",    1, 0, 0, 8'h00, 0, 1, 4'h0, 1, 0, 0, 0));
    apply(mk("s4_wr71",   1, 0, 1, 8'h71, 0, 0, 4'h0, 1, 1, 0, 0));
    apply(mk("s4_wr42",   1, 0, 1, 8'h42, 0, 0, 4'h0, 1, 2, 0, 0));
    apply(mk("s4_wait",   1, 0, 0, 8'h00, 1, 0, 4'h0, 1, 2, 0, 0));
    apply(mk("s4_run",    1, 0, 0, 8'h00, 1, 0, 4'h0, 0, 2, 0, 0));
    apply(mk("s4_n71a",   1, 1, 0, 8'h00, 1, 0, n1(8'h71), 0, 2, 0, 0));
    apply(mk("s4_stop",   1, 0, 0, 8'h00, 0, 0, 4'h0, 1, 2, 0, 0));
    apply(mk("s4_rewait", 1, 0, 0, 8'h00, 1, 0, 4'h0, 1, 2, 0, 0));
    apply(mk("s4_rerun",  1, 0, 0, 8'h00, 1, 0, 4'h0, 0, 2, 0, 0));
    apply(mk("s4_n71b",   1, 1, 0, 8'h00, 1, 0, n2(8'h71), 0, 1, 0, 0));
    apply(mk("s4_n42a",   1, 1, 0, 8'h00, 1, 0, n1(8'h42), 0, 1, 0, 0));
    apply(mk("s4_n42b",   1, 1, 0, 8'h00, 1, 0, n2(8'h42), 0, 0, 0, 0));

    // simultaneous push and pop at count 5 and at full
    apply(mk("s5_clr",    1, 0, 0, 8'h00, 0, 1, 4'h0, 1, 0, 0, 0));
    for (int unsigned i = 1; i <= 5; i++)
      apply(mk($sformatf("s5_wr_%0d", i), 1, 0, 1, 8'(i * 17), 0, 0,
               4'h0, 1, int'(i), 0, 0));
    apply(mk("s5_wait",   1, 0, 0, 8'h00, 1, 0, 4'h0, 1, 5, 0, 0));
    apply(mk("s5_run",    1, 0, 0, 8'h00, 1, 0, 4'h0, 0, 5, 0, 0));
    apply(mk("s5_n11a",   1, 1, 0, 8'h00, 1, 0, n1(8'h11), 0, 5, 0, 0));
    apply(mk("s5_pushpop",1, 1, 1, 8'h66, 1, 0, n2(8'h11), 0, 5, 0, 0));
    apply(mk("s5_stop",   1, 0, 0, 8'h00, 0, 0, 4'h0, 1, 5, 0, 0));
    for (int unsigned i = 0; i < 11; i++)
      apply(mk($sformatf("s5_fill_%0d", i), 1, 0, 1, 8'(8'h80 + i), 0, 0,
               4'h0, 1, int'(6 + i), 0, 0));
    apply(mk("s5_wait2",  1, 0, 0, 8'h00, 1, 0, 4'h0, 1, 16, 0, 0));
    apply(mk("s5_run2",   1, 0, 0, 8'h00, 1, 0, 4'h0, 0, 16, 0, 0));
    apply(mk("s5_n22a",   1, 1, 0, 8'h00, 1, 0, n1(8'h22), 0, 16, 0, 0));
    apply(mk("s5_fullpp", 1, 1, 1, 8'h77, 1, 0, n2(8'h22), 0, 16, 0, 0));
    apply(mk("s5_ovf",    1, 0, 1, 8'h88, 1, 0, n2(8'h22), 0, 16, 1, 0));

    // asynchronous reset while playing with a full FIFO
    @(negedge clk);
    bus.wr = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_rst", 4'h0, 1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk("post_rst",  1, 0, 0, 8'h00, 0, 0, 4'h0, 1, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
